// File: rtl/k_counter.sv
// k_counter: DPLL loop filter with independent modulo-2^k up/down counters and quiet-window lock detect
module k_counter #(
  parameter int MAX_K       = 16,
  parameter int LOCK_WINDOW = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       dnUp,
  input  logic [4:0] kSel,
  output logic       carry,
  output logic       borrow,
  output logic       locked
);
  localparam int QW = $clog2(LOCK_WINDOW + 1);
  localparam logic [QW-1:0] LW = QW'(LOCK_WINDOW);
  logic [MAX_K-1:0] up_cnt, dn_cnt, up_nx, dn_nx, m1;
  logic [4:0] k_q, k_eff;
  logic [QW-1:0] quiet, quiet_nx;
  logic chg, up_ev, dn_ev, carry_nx, borrow_nx;
  always_comb begin
    k_eff = kSel < 5'd3 ? 5'd3 : kSel > 5'(MAX_K) ? 5'(MAX_K) : kSel;
    chg = k_eff != k_q;
    m1 = (MAX_K'(1) << k_q) - MAX_K'(1);
    up_ev = !chg && enable && !dnUp;
    dn_ev = !chg && enable && dnUp;
    carry_nx = up_ev && up_cnt == m1;
    borrow_nx = dn_ev && dn_cnt == m1;
    up_nx = chg || carry_nx ? '0 : up_ev ? up_cnt + MAX_K'(1) : up_cnt;
    dn_nx = chg || borrow_nx ? '0 : dn_ev ? dn_cnt + MAX_K'(1) : dn_cnt;
    quiet_nx = chg || carry_nx || borrow_nx ? '0 : quiet == LW ? quiet : quiet + QW'(1);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up_cnt <= '0;
      dn_cnt <= '0;
      k_q    <= 5'd3;
      quiet  <= '0;
      carry  <= 1'b0;
      borrow <= 1'b0;
    end else begin
      up_cnt <= up_nx;
      dn_cnt <= dn_nx;
      k_q    <= k_eff;
      quiet  <= quiet_nx;
      carry  <= carry_nx;
      borrow <= borrow_nx;
    end
  end
  assign locked = quiet == LW;
endmodule

// File: tb/tb_k_counter.sv
// tb_k_counter: directed and random stimulus against a sample-counting reference model
module tb_k_counter;
  localparam int MAXK = 6;
  localparam int LW = 16;
  logic clk = 0, reset = 1, enable = 0, dnUp = 0;
  logic [4:0] kSel = 5'd3;
  logic carry, borrow, locked;
  int n_chk = 0, n_fail = 0;
  int mu = 0, md = 0, mk = 3, since = 0;
  bit ec = 0, eb = 0;

  always #5 clk = ~clk;

  k_counter #(.MAX_K(MAXK), .LOCK_WINDOW(LW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .dnUp(dnUp), .kSel(kSel),
    .carry(carry), .borrow(borrow), .locked(locked)
  );

  function automatic int clampk(input int k);
    return k < 3 ? 3 : k > MAXK ? MAXK : k;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("carry", {31'b0, carry}, {31'b0, ec});
    chk("borrow", {31'b0, borrow}, {31'b0, eb});
    chk("locked", {31'b0, locked}, {31'b0, since >= LW});
    chk("upCnt", 32'(dut.up_cnt), mu);
    chk("dnCnt", 32'(dut.dn_cnt), md);
  endtask

  task automatic model_reset();
    mu = 0; md = 0; mk = 3; since = 0; ec = 0; eb = 0;
  endtask

  // One clock: apply inputs, then advance the model by one sample and compare after the edge
  task automatic step(input bit en, input bit dn, input int k);
    int ke;
    enable = en; dnUp = dn; kSel = 5'(k);
    @(posedge clk);
    ke = clampk(k);
    ec = 0; eb = 0;
    if (ke != mk) begin
      mk = ke; mu = 0; md = 0; since = 0;
    end else begin
      if (en && !dn) begin
        mu++;
        if (mu == (1 << mk)) begin ec = 1; mu = 0; end
      end else if (en && dn) begin
        md++;
        if (md == (1 << mk)) begin eb = 1; md = 0; end
      end
      since = (ec || eb) ? 0 : since + 1;
    end
    #1 check_all();
  endtask

  task automatic do_reset();
    reset = 0;
    model_reset();
    #2 check_all();
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    int kr;
    #1 reset = 0;
    #1 check_all();
    #98 reset = 1;
    for (int i = 0; i < 24; i++) step(1, 0, 3);
    for (int i = 0; i < 33; i++) step(1, 1, 4);
    for (int i = 0; i < 17; i++) step(1, i[0], 3);
    for (int i = 0; i < 32; i++) step(!i[0], 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 3);
    for (int i = 0; i < 34; i++) step(1, 0, 5);
    for (int i = 0; i < 70; i++) step(1, 0, 20);
    for (int i = 0; i < 20; i++) step(0, 0, 3);
    for (int i = 0; i < 8; i++) step(1, 0, 3);
    for (int i = 0; i < 20; i++) step(0, 0, 3);
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 0, 3);
    kr = 3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) kr = $urandom_range(0, 9);
      if ($urandom_range(0, 599) == 0) do_reset();
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), kr);
      chk("exclusive", {31'b0, carry & borrow}, 32'd0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/k_counter.md
# k_counter

Loop-filter stage of the DPLL, directly upstream of the increment/decrement counter. It integrates the phase detector's up/down decision with a pair of modulo-M counters. It emits one-cycle `carry` pulses that drive the ID counter's `incIn` and one-cycle `borrow` pulses that drive its `decIn`. It also reports a simple lock indication, based on the absence of corrections over a programmable window.

## Interface
- `MAX_K`, 16: counter width in bits; largest modulus exponent accepted.
- `LOCK_WINDOW`, 256: number of consecutive correction-free clocks required to assert `locked`.
- `clk` input 1: system clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-low reset; all state cleared while low.
- `enable` input 1: sample qualifier; `dnUp` is counted only when high.
- `dnUp` input 1: phase detector output.
  - 0: count up (VCO lagging).
  - 1: count down (VCO leading).
- `kSel` input 5: modulus exponent. Modulus M = 2^kEff, where kEff = clamp(kSel, 3, MAX_K).
- `carry` output 1: registered one-cycle pulse; connects to ID counter `incIn`.
- `borrow` output 1: registered one-cycle pulse; connects to ID counter `decIn`.
- `locked` output 1: high after LOCK_WINDOW consecutive clocks with no correction pulse.

## Operation
- State:
  - `upCnt`, `dnCnt`: MAX_K bits each.
  - `kQ`: registered kEff.
  - `quietCnt`: clog2(LOCK_WINDOW+1) bits.
  - `carry`, `borrow` registers.
- Modulus change:
  - Each cycle, the block compares kEff with `kQ`.
  - If they differ: load `kQ` with kEff and clear `upCnt`, `dnCnt` and `quietCnt`.
  - In that cycle the `dnUp` sample is discarded, and `carry`/`borrow` are driven 0 at that edge.
- Up count (enable=1, dnUp=0, no modulus change):
  - If `upCnt` == M-1: `upCnt` <= 0 and `carry` <= 1.
  - Otherwise: `upCnt` <= `upCnt`+1 and `carry` <= 0.
  - `dnCnt` holds.
- Down count (enable=1, dnUp=1, no modulus change):
  - Symmetric to the up count, using `dnCnt` and `borrow`.
  - `upCnt` holds.
- enable=0: both counters hold; `carry` and `borrow` <= 0.
- Counters are independent, as in the classic K-counter:
  - A carry does not clear `dnCnt`.
  - A borrow does not clear `upCnt`.
- `carry` and `borrow` are mutually exclusive by construction, because `dnUp` selects exactly one counter. They are never high in the same cycle.
- Width rule: counters compare against M-1 computed at MAX_K bits; no wrap occurs above M-1.
- Lock window:
  - At each edge where the next `carry` or `borrow` value is 1, `quietCnt` <= 0.
  - Otherwise `quietCnt` increments, saturating at LOCK_WINDOW.
  - `locked` = (`quietCnt` == LOCK_WINDOW), decoded combinationally from the register.
  - `locked` is independent of `enable`: disabled clocks count as quiet.

## Timing
- Reset (reset low, asynchronous):
  - `upCnt` = `dnCnt` = 0; `quietCnt` = 0.
  - `kQ` = clamp(3) = 3.
  - `carry` = `borrow` = `locked` = 0.
- Release: the first rising edge with reset high is a normal operating edge. If kEff ≠ 3 at that edge, it is a modulus-change edge.
- Latency:
  - A pulse appears on the edge that consumes the M-th same-direction enabled sample.
  - Each pulse is high for exactly one clock.
  - The ID counter sees it at its next edge.
- Maximum pulse rate: one pulse every M enabled cycles per direction. M ≥ 8, so the output is never high on consecutive clocks.
- `locked` falls in the same cycle a correction pulse is visible.
- `locked` rises exactly LOCK_WINDOW clocks after the last pulse cycle, or after reset/modulus change.
- Reset asserted mid-count: the partial count is lost, and any pulse in flight is cleared immediately.

## Test plan
- Basic up count:
  - Stimulus: reset low 100 ns then high; kSel=3; enable=1; dnUp=0 held for 24 clocks.
  - Required: `carry` high for one clock on clocks 8, 16 and 24; `borrow` never high.
- Basic down count:
  - Stimulus: kSel=4; dnUp=1 for 32 clocks.
  - Required: `borrow` pulses on clocks 16 and 32; `upCnt` unchanged.
- Independent counters:
  - Stimulus: kSel=3; alternate dnUp 0/1 every clock for 16 clocks.
  - Required: one `carry` and one `borrow`, each at the 8th sample of its direction (clocks 15 and 16).
- Enable gating and clamp:
  - Stimulus: kSel=1; dnUp=0; enable toggled 1/0 each clock.
  - Required: M treated as 8; first `carry` follows the 8th enabled sample (clock 15).
- Modulus change mid-count:
  - Stimulus: kSel=3; 5 up samples; then kSel=5.
  - Required: no pulse at the change edge; counters cleared; next `carry` after 32 further up samples.
- Lock detect, with LOCK_WINDOW=16:
  - Stimulus: kSel=3; enable=0 for 20 clocks; then 8 up samples.
  - Required: `locked` rises at clock 16; falls with `carry` at clock 28; reset asserted mid-window clears `locked` immediately.
